ram_w_reader: RTL and testbench

//  Read-side sequencer for the weight RAM in the IMG2COL GEMM datapath. On a start pulse it drives
//  the RAM port (ena/wea/addra) to read a contiguous weight tile, repeated N times for weight reuse

---
 rtl/ram_w_reader_pkg.sv | 22 ++
 rtl/ram_w_rd_fifo.sv | 51 +++++
 rtl/ram_w_reader.sv | 134 +++++++++++++
 tb/tb_ram_w_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_w_reader_pkg.sv
// Shared types for the weight-RAM read sequencer: FSM states, default geometry
// and the tagged word that travels through the output buffer.
package ram_w_reader_pkg;

  localparam int WEIGHT_WIDTH = 16;
  localparam int WADDR_SIZE   = 6;
  localparam int WMEM_LENGTH  = 48;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } rd_state_t;

  // eoj marks the final word of the whole job and is only ever set together with last
  typedef struct packed {
    logic [WEIGHT_WIDTH-1:0] data;
    logic                    last;
    logic                    eoj;
  } w_tag_t;

endpackage

// File: rtl/ram_w_rd_fifo.sv
// Synchronous skid FIFO of tagged weight words; head is shown combinationally,
// and push+pop on a full FIFO is accepted.
module ram_w_rd_fifo
  import ram_w_reader_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  w_tag_t        push_tag,
  input  logic          pop,
  output w_tag_t        head,
  output logic          valid,
  output logic [PW:0]   count
);

  w_tag_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (PW+1)'(DEPTH)) || do_pop);
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ram_w_reader.sv
// Weight-RAM read sequencer: walks a tile cfg_repeat times, absorbs the 1-cycle
// RAM latency and streams tagged words through a credit-guarded skid FIFO.
module ram_w_reader
  import ram_w_reader_pkg::*;
#(
  parameter int DATA_WIDTH = WEIGHT_WIDTH,
  parameter int ADDR_SIZE  = WADDR_SIZE,
  parameter int MEM_LENGTH = WMEM_LENGTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_SIZE-1:0]  cfg_base,
  input  logic [ADDR_SIZE-1:0]  cfg_len,
  input  logic [7:0]            cfg_repeat,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_SIZE-1:0]  ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  m_end
);

  localparam int                   CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_SIZE-1:0] ADDR_LAST = ADDR_SIZE'(MEM_LENGTH - 1);

  rd_state_t             state, state_nx;
  logic [ADDR_SIZE-1:0]  base_q, len_q, addr_q, word_q;
  logic [7:0]            rep_q, pass_q;
  logic                  inflight_q, tag_last_q, tag_end_q, done_q;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_valid, pop, credit, issue;
  logic                  word_last, pass_last, drain_done, start_ok, start_nil;
  w_tag_t                head, push_tag;

  assign pop        = fifo_valid && m_ready;
  // A word popped this cycle frees its slot before the new read lands.
  assign credit     = (int'(fifo_count) + int'(inflight_q)) < (FIFO_DEPTH + int'(pop));
  assign issue      = (state == S_ISSUE) && credit;
  assign word_last  = (word_q == len_q - 1'b1);
  assign pass_last  = (pass_q == rep_q - 8'd1);
  assign start_ok   = (state == S_IDLE) && start && (cfg_len != '0) && (cfg_repeat != '0);
  assign start_nil  = (state == S_IDLE) && start && ((cfg_len == '0) || (cfg_repeat == '0));
  assign drain_done = (state == S_DRAIN) && !inflight_q &&
                      ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop));

  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nx = S_ISSUE;
      S_ISSUE: if (issue && word_last && pass_last) state_nx = S_DRAIN;
      S_DRAIN: if (drain_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      rep_q      <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      pass_q     <= '0;
      inflight_q <= 1'b0;
      tag_last_q <= 1'b0;
      tag_end_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      done_q     <= drain_done || start_nil;
      inflight_q <= issue;
      tag_last_q <= issue && word_last;
      tag_end_q  <= issue && word_last && pass_last;
      if (start_ok) begin
        base_q <= cfg_base;
        len_q  <= cfg_len;
        rep_q  <= cfg_repeat;
        addr_q <= cfg_base;
        word_q <= '0;
        pass_q <= '0;
      end else if (issue) begin
        if (word_last) begin
          word_q <= '0;
          addr_q <= base_q;
          pass_q <= pass_q + 8'd1;
        end else begin
          word_q <= word_q + 1'b1;
          addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    push_tag      = '0;
    push_tag.data = ram_douta;
    push_tag.last = tag_last_q;
    push_tag.eoj  = tag_end_q;
  end

  ram_w_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_tag (push_tag),
    .pop      (pop),
    .head     (head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign ram_ena   = issue;
  assign ram_wea   = 1'b0;
  assign ram_addra = addr_q;
  assign ram_dina  = '0;
  assign m_valid   = fifo_valid;
  assign m_data    = head.data;
  assign m_last    = fifo_valid && head.last;
  assign m_end     = fifo_valid && head.eoj;

endmodule

// File: tb/tb_ram_w_reader.sv
// Scoreboard bench for ram_w_reader: a RAM model answers reads, expected addresses
// and words are queued per job, and a negedge monitor pops and compares them.
module tb_ram_w_reader;
  import ram_w_reader_pkg::*;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int ML = 48;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base, cfg_len;
  logic [7:0]    cfg_repeat;
  logic          busy, done, ram_ena, ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina, ram_douta;
  logic          m_valid, m_ready, m_last, m_end;
  logic [DW-1:0] m_data;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          fin;
  } exp_t;

  exp_t          exp_q[$];
  int            addr_q[$];
  logic [DW-1:0] mem [ML];
  int checks = 0, errors = 0, cyc = 0;
  int rdy_mode = 0;
  int first_valid_cyc = -1, last_hs_cyc = 0;
  int first_ena_cyc = -1, last_ena_cyc = 0;
  int n_issued = 0, n_popped = 0, done_seen = 0;

  ram_w_reader #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .MEM_LENGTH(ML), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_repeat(cfg_repeat), .busy(busy), .done(done), .ram_ena(ram_ena), .ram_wea(ram_wea),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_end(m_end)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_ena) ram_douta <= mem[ram_addra];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(99) < 30);
      default: m_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_word(input int a, input logic [DW-1:0] d, input logic l, input logic f);
    addr_q.push_back(a);
    exp_q.push_back('{data: d, last: l, fin: f});
  endtask

  task automatic push_job(input int base, input int len, input int rep);
    for (int p = 0; p < rep; p++)
      for (int k = 0; k < len; k++) begin
        int a = (base + k) % ML;
        push_word(a, mem[a], k == len - 1, (k == len - 1) && (p == rep - 1));
      end
  endtask

  // Monitor: address stream, stall stability, output scoreboard, credit bound.
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l, hold_e;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("valid_held", m_valid, 1);
        check("data_held", {m_data, m_last, m_end}, {hold_d, hold_l, hold_e});
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        n_popped++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e.data);
          check("m_last", m_last, e.last);
          check("m_end", m_end, e.fin);
        end
      end
      if (ram_ena) begin
        n_issued++;
        if (first_ena_cyc < 0) first_ena_cyc = cyc;
        last_ena_cyc = cyc;
        check("ram_wea", ram_wea, 0);
        check("credit_bound", (n_issued - n_popped) <= FD, 1);
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ram_ena: got addr %0d expected no read", ram_addra);
        end else check("ram_addra", ram_addra, addr_q.pop_front());
      end
      if (done) done_seen++;
      stall_q = m_valid && !m_ready;
      hold_d = m_data; hold_l = m_last; hold_e = m_end;
    end
  end

  task automatic pulse_start(input int base, input int len, input int rep, output int c0);
    @(posedge clk); #1;
    cfg_base = AW'(base); cfg_len = AW'(len); cfg_repeat = 8'(rep);
    start = 1'b1; c0 = cyc;
    first_valid_cyc = -1; first_ena_cyc = -1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int base, input int len, input int rep);
    int c0, t, n0;
    bit nil;
    nil = (len == 0) || (rep == 0);
    n0 = n_issued;
    pulse_start(base, len, rep, c0);
    t = 0;
    do begin @(negedge clk); t++; end while (!done && t < 3000);
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done (job base %0d len %0d rep %0d)", base, len, rep);
    end else begin
      check("busy_at_done", busy, 0);
      if (nil) begin
        check("nil_done_cyc", cyc, c0 + 1);
        check("nil_no_ena", n_issued, n0);
      end else begin
        check("done_cyc", cyc, last_hs_cyc + 1);
        check("first_valid_lat", first_valid_cyc, c0 + 3);
        if (rdy_mode == 0) check("ena_back_to_back", last_ena_cyc - first_ena_cyc, len * rep - 1);
      end
      @(negedge clk);
      check("done_one_pulse", done, 0);
    end
    check("words_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
  endtask

  initial begin
    int c0, d0;
    for (int i = 0; i < ML; i++) mem[i] = DW'(16'hC000 + i * 3);
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_repeat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_ena", ram_ena, 0);
    check("rst_ram_addra", ram_addra, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last_end", {m_last, m_end}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;

    // base 0, len 4: mem[0..3] = C000,C003,C006,C009
    rdy_mode = 0;
    push_word(0, 16'hC000, 0, 0); push_word(1, 16'hC003, 0, 0);
    push_word(2, 16'hC006, 0, 0); push_word(3, 16'hC009, 1, 1);
    run_job(0, 4, 1);

    // wrap: 46,47,0,1 -> C08A,C08D,C000,C003
    push_word(46, 16'hC08A, 0, 0); push_word(47, 16'hC08D, 0, 0);
    push_word(0, 16'hC000, 0, 0);  push_word(1, 16'hC003, 1, 1);
    run_job(46, 4, 1);

    // len 3 x 3 with a start pulse landing mid-job that must be ignored
    push_job(10, 3, 3);
    fork
      run_job(10, 3, 3);
      begin
        repeat (3) @(posedge clk);
        #1 cfg_base = 6'd30; cfg_len = 6'd5; cfg_repeat = 8'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join

    rdy_mode = 1;
    push_job(40, 16, 2);
    run_job(40, 16, 2);

    rdy_mode = 0;
    push_job(7, 1, 3);
    run_job(7, 1, 3);

    run_job(12, 0, 2);
    run_job(12, 5, 0);

    // abort mid-job with the FIFO holding words
    rdy_mode = 2;
    push_job(5, 16, 2);
    pulse_start(5, 16, 2, c0);
    repeat (10) @(negedge clk);
    check("fifo_filled_before_rst", m_valid, 1);
    check("busy_before_rst", busy, 1);
    d0 = done_seen;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_ram_ena", ram_ena, 0);
    check("abort_ram_addra", ram_addra, 0);
    check("abort_flags", {done, m_last, m_end}, 3'b000);
    exp_q.delete(); addr_q.delete();
    n_issued = 0; n_popped = 0;
    @(posedge clk); #1 rst = 1'b0;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    check("abort_no_done", done_seen, d0);
    check("abort_no_valid", m_valid, 0);
    push_job(20, 4, 2);
    run_job(20, 4, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
